// File: rtl/sram_arb_pkg.sv
// Shared types for the two-master SRAM arbiter: transaction FSM states and master index.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    typedef logic master_idx_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the master that was not granted last wins.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic [1:0]  req,
    input  logic        enable,
    input  master_idx_t last_grant,
    output logic [1:0]  gnt,
    output master_idx_t winner
);

    // Pick the winner and form a one-hot grant only when enabled
    always_comb begin
        winner = 1'b0;
        gnt    = 2'b00;
        if (req == 2'b11) begin
            winner = ~last_grant;
        end else if (req[1]) begin
            winner = 1'b1;
        end else begin
            winner = 1'b0;
        end
        if (enable && (req != 2'b00)) begin
            gnt = winner ? 2'b10 : 2'b01;
        end else begin
            gnt = 2'b00;
        end
    end

endmodule

// File: rtl/sram_arbiter_chk.sv
// Simulation checks on the arbiter: SRAM handshake expectations and one-hot grant/response.
module sram_arbiter_chk
    import sram_arb_pkg::*;
#(
    parameter int NB = 4
) (
    input logic          CLK,
    input logic          RSTn,
    input state_t        state,
    input logic [NB-1:0] be_hold,
    input logic          sram_data_valid,
    input logic          sram_wack,
    input logic [1:0]    gnt,
    input logic [1:0]    rvalid
);

    a_rd_valid: assert property (@(posedge CLK) disable iff (!RSTn)
        (state == RD) |-> sram_data_valid);

    a_wr_wack: assert property (@(posedge CLK) disable iff (!RSTn)
        ((state == WR) && (be_hold != '0)) |-> sram_wack);

    a_gnt_onehot: assert property (@(posedge CLK) disable iff (!RSTn)
        $onehot0(gnt));

    a_rvalid_onehot: assert property (@(posedge CLK) disable iff (!RSTn)
        $onehot0(rvalid));

endmodule

// File: rtl/sram_arbiter.sv
// Shares one split-port SRAM between two req/gnt/rvalid masters, one transaction in flight,
// sequencing the read port and the one-cycle-late write commit.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 2,
    localparam int DW = 8 << DATA_WIDTH,
    localparam int NB = 1 << DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic [1:0]            REQ,
    output logic [1:0]            GNT,
    output logic [1:0]            RVALID,
    input  logic [1:0]            WE,
    input  logic [2*NB-1:0]       BE,
    input  logic [63:0]           ADDR,
    input  logic [2*DW-1:0]       WDATA,
    output logic [DW-1:0]         RDATA,
    output logic [ADDR_WIDTH-1:0] SRAM_READ_ADDR,
    output logic                  SRAM_OE,
    input  logic [DW-1:0]         SRAM_DATA_OUT,
    input  logic                  SRAM_DATA_VALID,
    output logic [ADDR_WIDTH-1:0] SRAM_WRITE_ADDR,
    output logic [DW-1:0]         SRAM_DATA_IN,
    output logic [NB-1:0]         SRAM_BE,
    output logic                  SRAM_WE,
    input  logic                  SRAM_WACK
);

    state_t                  state_r;
    state_t                  state_nxt_s;
    master_idx_t             last_grant_r;
    master_idx_t             active_r;
    master_idx_t             winner_s;
    logic [1:0]              gnt_s;
    logic                    arb_en_s;
    logic                    grant_s;
    logic [31:0]             sel_addr_s;
    logic [ADDR_WIDTH-1:0]   sel_word_s;
    logic                    sel_we_s;
    logic [NB-1:0]           sel_be_s;
    logic [DW-1:0]           sel_wdata_s;
    logic [ADDR_WIDTH-1:0]   waddr_r;
    logic [DW-1:0]           wdata_r;
    logic [NB-1:0]           be_hold_r;
    logic                    unused_addr_s;

    assign arb_en_s = (state_r == IDLE) && RSTn;

    rr_arb2 u_arb (
        .req        (REQ),
        .enable     (arb_en_s),
        .last_grant (last_grant_r),
        .gnt        (gnt_s),
        .winner     (winner_s)
    );

    assign GNT         = gnt_s;
    assign grant_s     = |gnt_s;
    assign sel_addr_s  = winner_s ? ADDR[63:32] : ADDR[31:0];
    assign sel_word_s  = sel_addr_s[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign sel_we_s    = winner_s ? WE[1] : WE[0];
    assign sel_be_s    = winner_s ? BE[2*NB-1:NB] : BE[NB-1:0];
    assign sel_wdata_s = winner_s ? WDATA[2*DW-1:DW] : WDATA[DW-1:0];

    // Address bits above the SRAM range alias and byte-offset bits are ignored
    assign unused_addr_s = ^ADDR;

    assign SRAM_WRITE_ADDR = waddr_r;
    assign SRAM_DATA_IN    = wdata_r;

    // Next state, SRAM strobes in the grant cycle and the response in the following cycle
    always_comb begin
        state_nxt_s    = state_r;
        SRAM_OE        = 1'b0;
        SRAM_WE        = 1'b0;
        SRAM_BE        = '0;
        SRAM_READ_ADDR = '0;
        RVALID         = 2'b00;
        RDATA          = '0;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    if (sel_we_s) begin
                        state_nxt_s = WR;
                        SRAM_WE     = 1'b1;
                        SRAM_BE     = sel_be_s;
                    end else begin
                        state_nxt_s    = RD;
                        SRAM_OE        = 1'b1;
                        SRAM_READ_ADDR = sel_word_s;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD: begin
                state_nxt_s      = IDLE;
                RVALID[active_r] = 1'b1;
                RDATA            = SRAM_DATA_OUT;
            end
            WR: begin
                state_nxt_s      = IDLE;
                RVALID[active_r] = 1'b1;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state, arbitration history and the in-flight master
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            active_r     <= 1'b0;
            be_hold_r    <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (grant_s) begin
                last_grant_r <= winner_s;
                active_r     <= winner_s;
                be_hold_r    <= sel_we_s ? sel_be_s : '0;
            end else begin
                last_grant_r <= last_grant_r;
                active_r     <= active_r;
                be_hold_r    <= be_hold_r;
            end
        end
    end

    // Write hold registers stay unreset so a write signalled just before reset still commits intact
    always_ff @(posedge CLK) begin
        if (grant_s && sel_we_s) begin
            waddr_r <= sel_word_s;
            wdata_r <= sel_wdata_s;
        end else begin
            waddr_r <= waddr_r;
            wdata_r <= wdata_r;
        end
    end

    sram_arbiter_chk #(.NB(NB)) u_chk (
        .CLK             (CLK),
        .RSTn            (RSTn),
        .state           (state_r),
        .be_hold         (be_hold_r),
        .sram_data_valid (SRAM_DATA_VALID),
        .sram_wack       (SRAM_WACK),
        .gnt             (GNT),
        .rvalid          (RVALID)
    );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: vector table plus hand sequences for tie, reset-in-write cases.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int NB = 4;

    logic           CLK = 1'b0;
    logic           RSTn;
    logic [1:0]     REQ;
    logic [1:0]     GNT;
    logic [1:0]     RVALID;
    logic [1:0]     WE;
    logic [2*NB-1:0] BE;
    logic [63:0]    ADDR;
    logic [2*DW-1:0] WDATA;
    logic [DW-1:0]  RDATA;
    logic [AW-1:0]  SRAM_READ_ADDR;
    logic           SRAM_OE;
    logic [DW-1:0]  SRAM_DATA_OUT;
    logic           SRAM_DATA_VALID;
    logic [AW-1:0]  SRAM_WRITE_ADDR;
    logic [DW-1:0]  SRAM_DATA_IN;
    logic [NB-1:0]  SRAM_BE;
    logic           SRAM_WE;
    logic           SRAM_WACK;

    // SRAM model: registered read, write committed one cycle after WE/BE
    logic [DW-1:0]  mem [0:(1<<AW)-1];
    logic           we_d = 1'b0;
    logic [NB-1:0]  be_d = 4'h0;
    logic           pl_en;
    logic [AW-1:0]  pl_addr;
    logic [DW-1:0]  pl_data;

    always #5 CLK = ~CLK;

    always_ff @(posedge CLK) begin
        SRAM_DATA_VALID <= SRAM_OE;
        if (SRAM_OE) SRAM_DATA_OUT <= mem[SRAM_READ_ADDR];
        we_d <= SRAM_WE;
        be_d <= SRAM_BE;
        if (pl_en) mem[pl_addr] <= pl_data;
        if (we_d) begin
            for (int b = 0; b < NB; b++) begin
                if (be_d[b]) mem[SRAM_WRITE_ADDR][8*b +: 8] <= SRAM_DATA_IN[8*b +: 8];
            end
        end
    end
    assign SRAM_WACK = we_d && (be_d != 4'h0);

    sram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(2)) dut (
        .CLK             (CLK),
        .RSTn            (RSTn),
        .REQ             (REQ),
        .GNT             (GNT),
        .RVALID          (RVALID),
        .WE              (WE),
        .BE              (BE),
        .ADDR            (ADDR),
        .WDATA           (WDATA),
        .RDATA           (RDATA),
        .SRAM_READ_ADDR  (SRAM_READ_ADDR),
        .SRAM_OE         (SRAM_OE),
        .SRAM_DATA_OUT   (SRAM_DATA_OUT),
        .SRAM_DATA_VALID (SRAM_DATA_VALID),
        .SRAM_WRITE_ADDR (SRAM_WRITE_ADDR),
        .SRAM_DATA_IN    (SRAM_DATA_IN),
        .SRAM_BE         (SRAM_BE),
        .SRAM_WE         (SRAM_WE),
        .SRAM_WACK       (SRAM_WACK)
    );

    typedef struct packed {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [7:0]  be;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [1:0]  e_gnt;
        logic [1:0]  e_rv;
        logic [31:0] e_rdata;
        logic        e_oe;
        logic        e_we;
        logic [3:0]  e_be;
        logic [15:0] e_ra;
        logic        e_wack;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic [1:0] req, input logic [1:0] we, input logic [7:0] be,
                          input logic [63:0] addr, input logic [63:0] wdata);
        REQ = req; WE = we; BE = be; ADDR = addr; WDATA = wdata;
    endtask

    vec_t vecs [15];
    logic [1:0] tie_gnt [6];
    logic [1:0] tie_rv  [6];

    initial begin
        vecs[0]  = '{2'b00, 2'b00, 8'h00, {32'h0, 32'h0}, {32'h0, 32'h0}, 2'b00, 2'b00, 32'h0, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0};
        vecs[1]  = '{2'b10, 2'b00, 8'h00, {32'h14, 32'h0}, {32'h0, 32'h0}, 2'b10, 2'b00, 32'h0, 1'b1, 1'b0, 4'h0, 16'h5, 1'b0};
        vecs[2]  = '{2'b10, 2'b00, 8'h00, {32'h14, 32'h0}, {32'h0, 32'h0}, 2'b00, 2'b10, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0};
        vecs[3]  = '{2'b10, 2'b10, 8'h20, {32'h20, 32'h0}, {32'h0000AB00, 32'h0}, 2'b10, 2'b00, 32'h0, 1'b0, 1'b1, 4'b0010, 16'h0, 1'b0};
        vecs[4]  = '{2'b00, 2'b00, 8'h00, {32'h0, 32'h0}, {32'h0, 32'h0}, 2'b00, 2'b10, 32'h0, 1'b0, 1'b0, 4'h0, 16'h0, 1'b1};
        vecs[5]  = '{2'b10, 2'b00, 8'h00, {32'h20, 32'h0}, {32'h0, 32'h0}, 2'b10, 2'b00, 32'h0, 1'b1, 1'b0, 4'h0, 16'h8, 1'b0};
        vecs[6]  = '{2'b00, 2'b00, 8'h00, {32'h0, 32'h0}, {32'h0, 32'h0}, 2'b00, 2'b10, 32'h0000AB00, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0};
        vecs[7]  = '{2'b01, 2'b00, 8'h00, {32'h0, 32'h14}, {32'h0, 32'h0}, 2'b01, 2'b00, 32'h0, 1'b1, 1'b0, 4'h0, 16'h5, 1'b0};
        vecs[8]  = '{2'b01, 2'b00, 8'h00, {32'h0, 32'h14}, {32'h0, 32'h0}, 2'b00, 2'b01, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0};
        vecs[9]  = '{2'b01, 2'b00, 8'h00, {32'h0, 32'h00040017}, {32'h0, 32'h0}, 2'b01, 2'b00, 32'h0, 1'b1, 1'b0, 4'h0, 16'h5, 1'b0};
        vecs[10] = '{2'b01, 2'b00, 8'h00, {32'h0, 32'h00040017}, {32'h0, 32'h0}, 2'b00, 2'b01, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0};
        vecs[11] = '{2'b01, 2'b01, 8'h00, {32'h0, 32'h20}, {32'h0, 32'hFFFFFFFF}, 2'b01, 2'b00, 32'h0, 1'b0, 1'b1, 4'h0, 16'h0, 1'b0};
        vecs[12] = '{2'b00, 2'b00, 8'h00, {32'h0, 32'h0}, {32'h0, 32'h0}, 2'b00, 2'b01, 32'h0, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0};
        vecs[13] = '{2'b10, 2'b00, 8'h00, {32'h20, 32'h0}, {32'h0, 32'h0}, 2'b10, 2'b00, 32'h0, 1'b1, 1'b0, 4'h0, 16'h8, 1'b0};
        vecs[14] = '{2'b00, 2'b00, 8'h00, {32'h0, 32'h0}, {32'h0, 32'h0}, 2'b00, 2'b10, 32'h0000AB00, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0};
        tie_gnt = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        tie_rv  = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

        // Reset with preload; grants must stay low even with both masters requesting
        RSTn = 1'b0;
        pl_en = 1'b0; pl_addr = 16'h0; pl_data = 32'h0;
        set_in(2'b11, 2'b00, 8'h00, {32'h14, 32'h14}, 64'h0);
        #1;
        pl_en = 1'b1; pl_addr = 16'd5;  pl_data = 32'hDEADBEEF; step();
        pl_addr = 16'd8;  pl_data = 32'h0; step();
        pl_addr = 16'd16; pl_data = 32'h0; step();
        pl_en = 1'b0;
        @(negedge CLK);
        n_vec++;
        chk("rst_gnt", 64'(GNT), 64'h0);
        chk("rst_rvalid", 64'(RVALID), 64'h0);
        chk("rst_rdata", 64'(RDATA), 64'h0);
        chk("rst_oe_we_be", 64'({SRAM_OE, SRAM_WE, SRAM_BE}), 64'h0);
        chk("rst_raddr", 64'(SRAM_READ_ADDR), 64'h0);
        step();
        RSTn = 1'b1;

        // Table: single read, byte write + readback, back-to-back M0, aliased address, zero-BE write
        for (int i = 0; i < 15; i++) begin
            set_in(vecs[i].req, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata);
            @(negedge CLK);
            n_vec++;
            chk($sformatf("v%0d_gnt", i), 64'(GNT), 64'(vecs[i].e_gnt));
            chk($sformatf("v%0d_rvalid", i), 64'(RVALID), 64'(vecs[i].e_rv));
            chk($sformatf("v%0d_rdata", i), 64'(RDATA), 64'(vecs[i].e_rdata));
            chk($sformatf("v%0d_oe", i), 64'(SRAM_OE), 64'(vecs[i].e_oe));
            chk($sformatf("v%0d_we", i), 64'(SRAM_WE), 64'(vecs[i].e_we));
            chk($sformatf("v%0d_be", i), 64'(SRAM_BE), 64'(vecs[i].e_be));
            chk($sformatf("v%0d_raddr", i), 64'(SRAM_READ_ADDR), 64'(vecs[i].e_ra));
            chk($sformatf("v%0d_wack", i), 64'(SRAM_WACK), 64'(vecs[i].e_wack));
            step();
        end
        chk("zero_be_mem8", 64'(mem[8]), 64'h0000AB00);

        // Tie from reset: M0, M1, M0 at cycles 0, 2, 4
        set_in(2'b00, 2'b00, 8'h00, 64'h0, 64'h0);
        RSTn = 1'b0;
        step();
        RSTn = 1'b1;
        set_in(2'b11, 2'b00, 8'h00, {32'h14, 32'h14}, 64'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            n_vec++;
            chk($sformatf("tie%0d_gnt", c), 64'(GNT), 64'(tie_gnt[c]));
            chk($sformatf("tie%0d_rvalid", c), 64'(RVALID), 64'(tie_rv[c]));
            step();
        end

        // Reset during the write response cycle: data still commits, no response
        set_in(2'b01, 2'b01, 8'h0F, {32'h0, 32'h40}, {32'h0, 32'h12345678});
        @(negedge CLK);
        n_vec++;
        chk("rstwr_gnt", 64'(GNT), 64'h1);
        chk("rstwr_we", 64'(SRAM_WE), 64'h1);
        step();
        set_in(2'b11, 2'b00, 8'h00, {32'h40, 32'h40}, 64'h0);
        RSTn = 1'b0;
        @(negedge CLK);
        n_vec++;
        chk("rstwr_rvalid", 64'(RVALID), 64'h0);
        chk("rstwr_gnt_in_rst", 64'(GNT), 64'h0);
        chk("rstwr_state", 64'(dut.state_r), 64'(IDLE));
        chk("rstwr_waddr", 64'(SRAM_WRITE_ADDR), 64'd16);
        chk("rstwr_wdata", 64'(SRAM_DATA_IN), 64'h12345678);
        step();
        RSTn = 1'b1;
        chk("rstwr_mem16", 64'(mem[16]), 64'h12345678);
        @(negedge CLK);
        n_vec++;
        chk("post_rst_gnt", 64'(GNT), 64'h1);
        chk("post_rst_raddr", 64'(SRAM_READ_ADDR), 64'd16);
        step();
        set_in(2'b00, 2'b00, 8'h00, 64'h0, 64'h0);
        @(negedge CLK);
        n_vec++;
        chk("post_rst_rvalid", 64'(RVALID), 64'h1);
        chk("post_rst_rdata", 64'(RDATA), 64'h12345678);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
